// File: rtl/mouse_to_cell.sv
// mouse_to_cell: converts a mouse click in screen pixels into the board cell
// drawn under it. It uses the same cell pitch and MARGIN as the button drawer.
// Column and row come from repeated subtraction, so the block needs no divider.
// It resolves one click at a time and pulses valid when the result is ready.
module mouse_to_cell #(
  parameter int MARGIN = 5,
  parameter int POS_W  = 12,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  input  logic             click,
  input  logic [10:0]      board_xpos,
  input  logic [10:0]      board_ypos,
  input  logic [6:0]       button_size,
  input  logic [IDX_W-1:0] board_size,
  output logic             busy,
  output logic             valid,
  output logic             hit,
  output logic             in_face,
  output logic [IDX_W-1:0] cell_x,
  output logic [IDX_W-1:0] cell_y
);

  localparam int XW = POS_W + 1;
  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    rx_q, rx_d;
  logic [XW-1:0]    ry_q, ry_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic             miss_q, miss_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             hit_q, hit_d;
  logic             face_q, face_d;
  logic [IDX_W-1:0] cx_q, cx_d;
  logic [IDX_W-1:0] cy_q, cy_d;

  // Operands zero-extended to the working width so that no compare wraps.
  logic [XW-1:0] mx_ext, my_ext, bx_ext, by_ext, size_ext;
  logic          early_miss;
  logic          col_last, row_last;
  logic          rx_ge, ry_ge;
  logic          rx_face, ry_face;

  // Decode the working-width operands and the per-step comparisons.
  always_comb begin
    mx_ext   = XW'(mouse_xpos);
    my_ext   = XW'(mouse_ypos);
    bx_ext   = XW'(board_xpos);
    by_ext   = XW'(board_ypos);
    size_ext = XW'(button_size);
    // A click left of column 0 or above row 0, or a degenerate board, is
    // flagged before the offsets are latched. The offsets therefore never
    // underflow on a real hit.
    early_miss = (mx_ext <= bx_ext) || (my_ext < by_ext) ||
                 (button_size == 7'd0) || (board_size == '0);
    col_last = (CW'(col_q) + CW'(1)) == CW'(board_size);
    row_last = (CW'(row_q) + CW'(1)) == CW'(board_size);
    rx_ge    = rx_q >= size_ext;
    ry_ge    = ry_q >= size_ext;
    // The face is [MARGIN, size-MARGIN). The upper bound is tested as
    // rem+MARGIN < size, which stays correct even when size < MARGIN.
    rx_face  = (rx_q >= XW'(MARGIN)) &&
               ((XW+1)'(rx_q) + (XW+1)'(MARGIN) < (XW+1)'(button_size));
    ry_face  = (ry_q >= XW'(MARGIN)) &&
               ((XW+1)'(ry_q) + (XW+1)'(MARGIN) < (XW+1)'(button_size));
  end

  // Next-state logic: latch the offsets on a click, subtract one pitch per
  // cycle for the column and then for the row, and load the result on entry
  // to DONE.
  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    col_d   = col_q;
    row_d   = row_q;
    miss_d  = miss_q;
    hit_d   = hit_q;
    face_d  = face_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    unique case (state_q)
      IDLE: begin
        if (click) begin
          rx_d    = mx_ext - bx_ext - XW'(1);
          ry_d    = my_ext - by_ext;
          col_d   = '0;
          row_d   = '0;
          miss_d  = early_miss;
          state_d = DIV_X;
        end
      end
      DIV_X: begin
        if (miss_q || (rx_ge && col_last)) begin
          hit_d   = 1'b0;
          face_d  = 1'b0;
          cx_d    = '0;
          cy_d    = '0;
          state_d = DONE;
        end else if (rx_ge) begin
          rx_d  = rx_q - size_ext;
          col_d = col_q + IDX_W'(1);
        end else begin
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        if (ry_ge && row_last) begin
          hit_d   = 1'b0;
          face_d  = 1'b0;
          cx_d    = '0;
          cy_d    = '0;
          state_d = DONE;
        end else if (ry_ge) begin
          ry_d  = ry_q - size_ext;
          row_d = row_q + IDX_W'(1);
        end else begin
          hit_d   = 1'b1;
          face_d  = rx_face && ry_face;
          cx_d    = col_q;
          cy_d    = row_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State and result registers. Reset aborts any click in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      face_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      col_q   <= col_d;
      row_q   <= row_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      face_q  <= face_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign hit     = hit_q;
  assign in_face = face_q;
  assign cell_x  = cx_q;
  assign cell_y  = cy_q;

endmodule

// File: tb/tb_mouse_to_cell.sv
// Directed testbench for mouse_to_cell. The board sits at (100,50) with a
// pitch of 40 and 8 cells per side.
module tb_mouse_to_cell;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        click;
  logic [10:0] board_xpos, board_ypos;
  logic [6:0]  button_size;
  logic [4:0]  board_size;
  logic        busy, valid, hit, in_face;
  logic [4:0]  cell_x, cell_y;

  int checks = 0;
  int errors = 0;

  mouse_to_cell #(.MARGIN(5), .POS_W(12), .IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .click(click),
    .board_xpos(board_xpos), .board_ypos(board_ypos),
    .button_size(button_size), .board_size(board_size),
    .busy(busy), .valid(valid), .hit(hit), .in_face(in_face),
    .cell_x(cell_x), .cell_y(cell_y)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle click. On return the time is #1 after E0.
  task automatic do_click(input int x, input int y);
    @(negedge clk);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    click = 1'b1;
    @(posedge clk);
    #1;
    click = 1'b0;
  endtask

  // Count edges after E0 until valid is seen. Returns -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (in_face !== 1'b0) begin errors++; $display("FAIL reset_in_face: got %b expected 0", in_face); end
    checks++; if (cell_x !== 5'd0 || cell_y !== 5'd0) begin errors++; $display("FAIL reset_cell: got %0d,%0d expected 0,0", cell_x, cell_y); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scenario 1: (181,95) gives rx=80 and ry=45, so cell (2,1) with remainders 0 and 5.
  task automatic test_hit_border;
    int lat;
    do_click(181, 95);
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL hit1_latency: got %0d expected 5", lat); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit1_hit: got %b expected 1", hit); end
    checks++; if (cell_x !== 5'd2 || cell_y !== 5'd1) begin errors++; $display("FAIL hit1_cell: got %0d,%0d expected 2,1", cell_x, cell_y); end
    checks++; if (in_face !== 1'b0) begin errors++; $display("FAIL hit1_face: got %b expected 0", in_face); end
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hit1_after: got valid=%b busy=%b expected 0,0", valid, busy); end
    checks++; if (cell_x !== 5'd2 || hit !== 1'b1) begin errors++; $display("FAIL hit1_hold: got cx=%0d hit=%b expected 2,1", cell_x, hit); end
  endtask

  // Scenario 2: (226,175) gives rx=ry=125, so cell (3,3) with remainders 5 and 5, inside the face.
  task automatic test_face;
    int lat;
    do_click(226, 175);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL face_busy_e0: got %b expected 1", busy); end
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL face_latency: got %0d expected 8", lat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL face_busy_done: got %b expected 1", busy); end
    checks++; if (hit !== 1'b1 || in_face !== 1'b1) begin errors++; $display("FAIL face_flags: got hit=%b face=%b expected 1,1", hit, in_face); end
    checks++; if (cell_x !== 5'd3 || cell_y !== 5'd3) begin errors++; $display("FAIL face_cell: got %0d,%0d expected 3,3", cell_x, cell_y); end
    @(posedge clk);
    #1;
  endtask

  // Scenario 3: a click one pixel left of column 0, then a click past column 7.
  task automatic test_miss;
    int lat;
    do_click(100, 60);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL miss_left_latency: got %0d expected 1", lat); end
    checks++; if (hit !== 1'b0 || in_face !== 1'b0) begin errors++; $display("FAIL miss_left_flags: got hit=%b face=%b expected 0,0", hit, in_face); end
    checks++; if (cell_x !== 5'd0 || cell_y !== 5'd0) begin errors++; $display("FAIL miss_left_cell: got %0d,%0d expected 0,0", cell_x, cell_y); end
    @(posedge clk);
    #1;
    do_click(421, 60);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL miss_right_latency: got %0d expected 8", lat); end
    checks++; if (hit !== 1'b0 || cell_x !== 5'd0) begin errors++; $display("FAIL miss_right: got hit=%b cx=%0d expected 0,0", hit, cell_x); end
    @(posedge clk);
    #1;
  endtask

  // Scenario 4: a second click two cycles into scenario 2 must be ignored.
  task automatic test_back_to_back;
    int pulses = 0;
    int first = -1;
    do_click(226, 175);
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      click = (n == 2);
      if (n == 2) begin
        mouse_xpos = 12'd181;
        mouse_ypos = 12'd95;
      end
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    click = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    checks++; if (first !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", first); end
    checks++; if (cell_x !== 5'd3 || cell_y !== 5'd3 || in_face !== 1'b1) begin errors++; $display("FAIL b2b_result: got %0d,%0d face=%b expected 3,3,1", cell_x, cell_y, in_face); end
  endtask

  // Scenario 5: reset while the row is being resolved (DIV_Y runs from E4 to E8).
  task automatic test_reset_mid;
    int pulses = 0;
    int lat;
    do_click(226, 175);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || hit !== 1'b0 || in_face !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b valid=%b hit=%b face=%b expected 0", busy, valid, hit, in_face); end
    checks++; if (cell_x !== 5'd0 || cell_y !== 5'd0) begin errors++; $display("FAIL rstmid_cell: got %0d,%0d expected 0,0", cell_x, cell_y); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_novalid: got %0d pulses expected 0", pulses); end
    do_click(181, 95);
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_relatency: got %0d expected 5", lat); end
    checks++; if (cell_x !== 5'd2 || cell_y !== 5'd1 || hit !== 1'b1) begin errors++; $display("FAIL rstmid_result: got %0d,%0d hit=%b expected 2,1,1", cell_x, cell_y, hit); end
    @(posedge clk);
    #1;
  endtask

  // Scenario 6: a zero pitch gives an immediate miss and must not stall the FSM.
  task automatic test_zero_size;
    int lat;
    @(negedge clk);
    button_size = 7'd0;
    do_click(300, 300);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL zero_hit: got %b expected 0", hit); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b expected 0", busy); end
    @(negedge clk);
    button_size = 7'd40;
  endtask

  initial begin
    rst = 1'b1;
    click = 1'b0;
    mouse_xpos = '0;
    mouse_ypos = '0;
    board_xpos = 11'd100;
    board_ypos = 11'd50;
    button_size = 7'd40;
    board_size = 5'd8;
    test_reset;
    test_hit_border;
    test_face;
    test_miss;
    test_back_to_back;
    test_reset_mid;
    test_zero_size;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
